decode_rf: RTL and testbench
============================

DECODE_RF -- requirements
Module: decode_rf

Interface
REQ-001 Parameter DATA_W, default 8, register and operand width in bits (legal range 8..32).
REQ-002 Parameter NREG, default 8, number of general registers (power of two, 2..8); the register index is IR[10:8] / IR[7:5] modulo NREG.
REQ-003 T0  in  1  clock; every state element updates on its rising edge only.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  IR is valid this cycle.
REQ-006 in_ready  out  1  decoder accepts IR this cycle.
REQ-007 IR  in  16  instruction: [15:11] opcode, [10:8] rA, [7:5] rB, [7:0] X; opcode bit 15 = writes rA.
REQ-008 wb_en / wb_idx / wb_data  in  1 / 3 / DATA_W  write-back port into the register file.
REQ-009 out_valid  out  1  decoded bundle valid.
REQ-010 out_ready  in  1  downstream accepts the bundle.
REQ-011 op  out  5  registered opcode.
REQ-012 valA / valB  out  DATA_W  registered operand values of rA / rB.
REQ-013 X  out  8  registered IR[7:0].
REQ-014 Addr  out  DATA_W+8  registered {R[NREG-1], X}.
REQ-015 busy  out  NREG  scoreboard bits, one per register.

Function
REQ-016 Accept = in_valid && in_ready; on accept the output register loads op, valA, valB, X, Addr, and out_valid becomes 1 on the next edge (latency 1 cycle).
REQ-017 in_ready = (!out_valid || out_ready) && !hazard, combinational; in_ready does not depend on in_valid.
REQ-018 hazard = busy[rA] || busy[rB], masked per REQ-029 when bypass is compiled in.
REQ-019 out_valid clears on the edge after out_valid && out_ready when no new accept occurs; with simultaneous accept and out_ready, new data loads and out_valid stays 1.
REQ-020 While out_valid && !out_ready, all output fields hold stable.
REQ-021 wb_en writes wb_data into R[wb_idx mod NREG] on the edge; R0 is writable.
REQ-022 An accepted IR with bit 15 = 1 sets busy[rA] on the same edge.
REQ-023 wb_en clears busy[wb_idx]; if the same edge also sets the same index per REQ-022, the set takes priority and the bit remains 1.
REQ-024 Read operands are taken from the register-file contents before this edge's write-back unless forwarded per REQ-029.
REQ-025 Addr uses the same value of R[NREG-1] that valA/valB would see, including forwarding.
REQ-026 If rA == rB, valA and valB are identical.

Reset
REQ-027 When rst is sampled high: R[i] = i (zero-extended to DATA_W); busy = 0; out_valid = 0; op, valA, valB, X and Addr = 0. An in-flight bundle is discarded and any write-back that edge is ignored.
REQ-028 rst has priority over every other input; in_ready is 0 during the rst cycle.

Configuration
REQ-029 With DECODE_BYPASS_EN defined: a wb_en in the accepting cycle forwards wb_data to any operand whose index equals wb_idx, including Addr; a busy bit being cleared by that write-back does not cause a hazard.
REQ-030 Without DECODE_BYPASS_EN: no forwarding; a busy operand stalls until the cycle after its write-back, and operands always read the stored register value.

Verification
REQ-031 Reset, then IR=16'h0345 (rA=3, rB=2, X=8'h45), out_ready=1 -> next cycle out_valid=1, valA=3, valB=2, X=8'h45, Addr=16'h0745.
REQ-032 Accept IR=16'h8100 (write R1) -> busy[1]=1; next IR reads rB=1 -> in_ready=0 until wb_en with wb_idx=1 and wb_data=8'hAA; then valB=8'hAA (1 cycle earlier with bypass).
REQ-033 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; release -> the next accepted IR appears 1 cycle later.
REQ-034 Same edge: accept IR=16'h8200 and wb_en with wb_idx=2 -> busy[2] remains 1.
REQ-035 Assert rst while out_valid=1 and busy=8'h06 -> next cycle out_valid=0, busy=0, R5 reads 5.
REQ-036 Set DATA_W=16 and NREG=4; write R3=16'hBEEF, then IR with X=8'h12 -> Addr=24'hBEEF12; rA index 7 maps to R3.

Source files
------------

// File: rtl/decode_rf.sv
// decode_rf: instruction decode stage with register file, busy scoreboard and 1-deep output register.
// Optional write-back forwarding into the operand reads is enabled by defining DECODE_BYPASS_EN.
module decode_rf #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
) (
    input  logic                T0,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         IR,
    input  logic                wb_en,
    input  logic [2:0]          wb_idx,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          op,
    output logic [DATA_W-1:0]   valA,
    output logic [DATA_W-1:0]   valB,
    output logic [7:0]          X,
    output logic [DATA_W+7:0]   Addr,
    output logic [NREG-1:0]     busy
);
    localparam int IW = $clog2(NREG);
    localparam logic [IW-1:0] LAST = IW'(NREG - 1);

    logic [DATA_W-1:0] r [NREG];
    logic [IW-1:0]     ra, rb, wi;
    logic [DATA_W-1:0] rd_a, rd_b, rd_l;
    logic              hit_a, hit_b, hit_l, hazard, accept;
    logic [NREG-1:0]   busy_n;

    assign ra = IR[8 +: IW];
    assign rb = IR[5 +: IW];
    assign wi = wb_idx[IW-1:0];

`ifdef DECODE_BYPASS_EN
    assign hit_a = wb_en && wi == ra;
    assign hit_b = wb_en && wi == rb;
    assign hit_l = wb_en && wi == LAST;
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
    assign hit_l = 1'b0;
`endif

    assign rd_a = hit_a ? wb_data : r[ra];
    assign rd_b = hit_b ? wb_data : r[rb];
    assign rd_l = hit_l ? wb_data : r[LAST];

    // a forwarded operand is satisfied by the write-back that clears its busy bit
    assign hazard   = (busy[ra] && !hit_a) || (busy[rb] && !hit_b);
    assign in_ready = !rst && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // set after clear so a same-edge writer keeps its bit
    always_comb begin
        busy_n = busy;
        if (wb_en) busy_n[wi] = 1'b0;
        if (accept && IR[15]) busy_n[ra] = 1'b1;
    end

    always_ff @(posedge T0) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r[i] <= DATA_W'(i);
            busy      <= '0;
            out_valid <= 1'b0;
            op        <= '0;
            valA      <= '0;
            valB      <= '0;
            X         <= '0;
            Addr      <= '0;
        end else begin
            if (wb_en) r[wi] <= wb_data;
            busy <= busy_n;
            if (accept) begin
                op        <= IR[15:11];
                valA      <= rd_a;
                valB      <= rd_b;
                X         <= IR[7:0];
                Addr      <= {rd_l, IR[7:0]};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_rf.sv
// tb_decode_rf: directed checks of decode_rf (default 8x8 instance plus a 16-bit, 4-register instance).
module tb_decode_rf;
    logic T0 = 1'b0;
    always #5 T0 = ~T0;

    int checks = 0;
    int errors = 0;

    logic        rst, in_valid, wb_en, out_ready;
    logic [15:0] IR;
    logic [2:0]  wb_idx;
    logic [7:0]  wb_data;
    logic        in_ready, out_valid;
    logic [4:0]  op;
    logic [7:0]  valA, valB, X;
    logic [15:0] Addr;
    logic [7:0]  busy;

    logic        in_valid_b, wb_en_b;
    logic [15:0] IR_b;
    logic [2:0]  wb_idx_b;
    logic [15:0] wb_data_b;
    logic        in_ready_b, out_valid_b;
    logic [4:0]  op_b;
    logic [15:0] valA_b, valB_b;
    logic [7:0]  X_b;
    logic [23:0] Addr_b;
    logic [3:0]  busy_b;

    decode_rf dut (
        .T0(T0), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .IR(IR),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .op(op),
        .valA(valA), .valB(valB), .X(X), .Addr(Addr), .busy(busy)
    );

    decode_rf #(.DATA_W(16), .NREG(4)) dut_b (
        .T0(T0), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .IR(IR_b),
        .wb_en(wb_en_b), .wb_idx(wb_idx_b), .wb_data(wb_data_b),
        .out_valid(out_valid_b), .out_ready(1'b1), .op(op_b),
        .valA(valA_b), .valB(valB_b), .X(X_b), .Addr(Addr_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge T0);
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; wb_en = 0; out_ready = 1; IR = 0; wb_idx = 0; wb_data = 0;
        in_valid_b = 0; wb_en_b = 0; IR_b = 0; wb_idx_b = 0; wb_data_b = 0;
        step();
        in_valid = 1; IR = 16'h0345;
        #1 check("ready_in_rst", in_ready, 0);
        step();
        rst = 0; in_valid = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_valA", valA, 0);
        check("rst_Addr", Addr, 0);

        // wide instance: R3 write, index 7 folds onto R3
        wb_en_b = 1; wb_idx_b = 3; wb_data_b = 16'hBEEF;
        step();
        wb_en_b = 0; in_valid_b = 1; IR_b = 16'h0712;
        step();
        in_valid_b = 0;
        check("b_Addr", Addr_b, 24'hBEEF12);
        check("b_valA", valA_b, 16'hBEEF);
        check("b_valB", valB_b, 0);

        // basic decode
        in_valid = 1; IR = 16'h0345;
        #1 check("basic_ready", in_ready, 1);
        step();
        in_valid = 0;
        check("basic_valid", out_valid, 1);
        check("basic_valA", valA, 3);
        check("basic_valB", valB, 2);
        check("basic_X", X, 8'h45);
        check("basic_Addr", Addr, 16'h0745);
        check("basic_op", op, 0);
        step();
        check("drain_valid", out_valid, 0);

        // scoreboard stall on R1
        in_valid = 1; IR = 16'h8100;
        step();
        check("sb_busy", busy, 8'h02);
        check("sb_op", op, 5'h10);
        IR = 16'h0020;
        #1 check("sb_stall", in_ready, 0);
        step();
        check("sb_no_accept", out_valid, 0);
        wb_en = 1; wb_idx = 1; wb_data = 8'hAA;
        #1;
`ifdef DECODE_BYPASS_EN
        check("sb_wb_ready", in_ready, 1);
        step();
        wb_en = 0; in_valid = 0;
`else
        check("sb_wb_ready", in_ready, 0);
        step();
        wb_en = 0;
        #1 check("sb_after_ready", in_ready, 1);
        step();
        in_valid = 0;
`endif
        check("sb_valid", out_valid, 1);
        check("sb_valB", valB, 8'hAA);
        check("sb_valA", valA, 0);
        check("sb_busy_clr", busy, 0);

        // backpressure holds outputs
        out_ready = 0; in_valid = 1; IR = 16'h0345;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", in_ready, 0);
            step();
            check("bp_valid", out_valid, 1);
            check("bp_valB", valB, 8'hAA);
        end
        out_ready = 1;
        #1 check("bp_release_ready", in_ready, 1);
        step();
        in_valid = 0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_valA", valA, 3);
        check("bp_next_valB", valB, 2);
        step();

        // same-edge set and clear of busy[2]
        in_valid = 1; IR = 16'h8200; wb_en = 1; wb_idx = 2; wb_data = 8'h55;
        step();
        wb_en = 0;
        check("same_edge_busy", busy, 8'h04);
`ifdef DECODE_BYPASS_EN
        check("same_edge_valA", valA, 8'h55);
`else
        check("same_edge_valA", valA, 2);
`endif
        IR = 16'h8100;
        step();
        check("pre_rst_busy", busy, 8'h06);
        check("pre_rst_valid", out_valid, 1);

        // reset mid-flight; write-back this edge is dropped
        rst = 1; wb_en = 1; wb_idx = 5; wb_data = 8'hEE; IR = 16'h0345;
        #1 check("rst_ready", in_ready, 0);
        step();
        rst = 0; wb_en = 0; in_valid = 0;
        check("rst2_valid", out_valid, 0);
        check("rst2_busy", busy, 0);
        in_valid = 1; IR = 16'h05A0;
        step();
        in_valid = 0;
        check("r5_valA", valA, 5);
        check("r5_valB", valB, 5);
        check("r5_Addr", Addr, 16'h07A0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
